// File: rtl/param_router.sv
// param_router: N_PORTS input channels, each with its own FIFO, feeding one
// registered output stage through a round-robin or fixed-priority arbiter.
//   clk          rising-edge clock
//   rst          asynchronous active-low reset
//   in_data      per-channel data, channel i at [i*DATA_W +: DATA_W]
//   request      per-channel write request
//   ready        per-channel "FIFO not full" (combinational from occupancy)
//   out_data     routed word
//   out_valid    out_data/out_src hold a valid word
//   out_ready    downstream accepts the word
//   out_src      source channel of out_data
//   reject_count saturating count of requests refused for lack of space
module param_router #(
  parameter int unsigned N_PORTS    = 4,
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned ARB_MODE   = 0
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [N_PORTS*DATA_W-1:0]   in_data,
  input  logic [N_PORTS-1:0]          request,
  output logic [N_PORTS-1:0]          ready,
  output logic [DATA_W-1:0]           out_data,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [$clog2(N_PORTS)-1:0]  out_src,
  output logic [7:0]                  reject_count
);

  localparam int unsigned SRC_W = $clog2(N_PORTS);
  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned REJ_W = $clog2(N_PORTS + 1);

  logic                run;
  logic [PTR_W-1:0]    wr_ptr [N_PORTS];
  logic [PTR_W-1:0]    rd_ptr [N_PORTS];
  logic [CNT_W-1:0]    count  [N_PORTS];
  logic [DATA_W-1:0]   mem    [N_PORTS][FIFO_DEPTH];

  logic [N_PORTS-1:0]  full;
  logic [N_PORTS-1:0]  empty;
  logic [N_PORTS-1:0]  push;
  logic [N_PORTS-1:0]  pop;
  logic                load;
  logic                grant_valid;
  logic [SRC_W-1:0]    grant_idx;
  logic [SRC_W-1:0]    rr_idx;
  logic [SRC_W-1:0]    last_grant;
  logic [REJ_W-1:0]    rej_n;
  logic [8:0]          rej_sum;

  // FIFO status from registered occupancy only
  always_comb begin
    full  = '0;
    empty = '0;
    for (int i = 0; i < int'(N_PORTS); i++) begin
      full[i]  = (count[i] == CNT_W'(FIFO_DEPTH));
      empty[i] = (count[i] == '0);
    end
  end

  // run holds ready low from reset until the first edge after release
  assign ready = {N_PORTS{run}} & ~full;
  assign push  = request & ready;
  assign load  = ~out_valid | out_ready;

  // Arbiter; loops run from lowest to highest priority so the last hit wins
  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = '0;
    rr_idx      = '0;
    if (ARB_MODE == 1) begin
      for (int i = int'(N_PORTS) - 1; i >= 0; i--) begin
        if (!empty[i]) begin
          grant_valid = 1'b1;
          grant_idx   = SRC_W'(i);
        end
      end
    end else begin
      for (int k = int'(N_PORTS); k >= 1; k--) begin
        rr_idx = SRC_W'((int'(last_grant) + k) % int'(N_PORTS));
        if (!empty[rr_idx]) begin
          grant_valid = 1'b1;
          grant_idx   = rr_idx;
        end
      end
    end
  end

  always_comb begin
    pop = '0;
    if (load && grant_valid) pop[grant_idx] = 1'b1;
  end

  // Number of refused requests this cycle, added with saturation
  always_comb begin
    rej_n = '0;
    for (int i = 0; i < int'(N_PORTS); i++) begin
      rej_n = rej_n + REJ_W'(request[i] & ~ready[i]);
    end
    rej_sum = {1'b0, reject_count} + 9'(rej_n);
  end

  // FIFO pointers and occupancy
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      run <= 1'b0;
      for (int i = 0; i < int'(N_PORTS); i++) begin
        wr_ptr[i] <= '0;
        rd_ptr[i] <= '0;
        count[i]  <= '0;
      end
    end else begin
      run <= 1'b1;
      for (int i = 0; i < int'(N_PORTS); i++) begin
        if (push[i]) wr_ptr[i] <= wr_ptr[i] + PTR_W'(1);
        if (pop[i])  rd_ptr[i] <= rd_ptr[i] + PTR_W'(1);
        if (push[i] && !pop[i])      count[i] <= count[i] + CNT_W'(1);
        else if (!push[i] && pop[i]) count[i] <= count[i] - CNT_W'(1);
      end
    end
  end

  // FIFO storage; contents are don't-care once occupancy is cleared
  always_ff @(posedge clk) begin
    for (int i = 0; i < int'(N_PORTS); i++) begin
      if (push[i]) mem[i][wr_ptr[i]] <= in_data[i*int'(DATA_W) +: DATA_W];
    end
  end

  // Output register, round-robin history and reject counter
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid    <= 1'b0;
      out_data     <= '0;
      out_src      <= '0;
      last_grant   <= SRC_W'(N_PORTS - 1);
      reject_count <= '0;
    end else begin
      if (load) begin
        if (grant_valid) begin
          out_valid  <= 1'b1;
          out_data   <= mem[grant_idx][rd_ptr[grant_idx]];
          out_src    <= grant_idx;
          last_grant <= grant_idx;
        end else begin
          out_valid  <= 1'b0;
        end
      end
      reject_count <= rej_sum[8] ? 8'hFF : rej_sum[7:0];
    end
  end

endmodule

// File: tb/tb_param_router.sv
// Directed bench for param_router: a round-robin instance and a
// fixed-priority instance share clock, reset and data.
module tb_param_router;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] in_data;
  logic [3:0]  request;
  logic [3:0]  request_f;
  logic        out_ready;
  logic        out_ready_f;

  logic [3:0]  ready,     ready_f;
  logic [7:0]  out_data,  out_data_f;
  logic        out_valid, out_valid_f;
  logic [1:0]  out_src,   out_src_f;
  logic [7:0]  reject_count, reject_count_f;

  int checks = 0;
  int errors = 0;
  int accepted;

  always #5 clk = ~clk;

  param_router #(.N_PORTS(4), .DATA_W(8), .FIFO_DEPTH(4), .ARB_MODE(0)) dut_rr (
    .clk(clk), .rst(rst), .in_data(in_data), .request(request), .ready(ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_src(out_src), .reject_count(reject_count)
  );

  param_router #(.N_PORTS(4), .DATA_W(8), .FIFO_DEPTH(4), .ARB_MODE(1)) dut_fx (
    .clk(clk), .rst(rst), .in_data(in_data), .request(request_f), .ready(ready_f),
    .out_data(out_data_f), .out_valid(out_valid_f), .out_ready(out_ready_f),
    .out_src(out_src_f), .reject_count(reject_count_f)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Advance one edge and settle away from it
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst         = 1'b0;
    in_data     = '0;
    request     = '0;
    request_f   = '0;
    out_ready   = 1'b1;
    out_ready_f = 1'b1;

    // Reset state
    tick();
    tick();
    check("rst_ready",     32'(ready),          32'h0);
    check("rst_valid",     32'(out_valid),      32'h0);
    check("rst_data",      32'(out_data),       32'h0);
    check("rst_src",       32'(out_src),        32'h0);
    check("rst_reject",    32'(reject_count),   32'h0);
    check("rst_fx_ready",  32'(ready_f),        32'h0);
    check("rst_fx_reject", 32'(reject_count_f), 32'h0);
    #2 rst = 1'b1;
    tick();
    check("post_rst_ready", 32'(ready), 32'hF);

    // All four channels in one cycle, round-robin order twice
    for (int r = 0; r < 2; r++) begin
      in_data = 32'h4030_2010;
      request = 4'hF;
      tick();
      request = '0;
      for (int j = 0; j < 4; j++) begin
        tick();
        check("rr_valid", 32'(out_valid), 32'h1);
        check("rr_src",   32'(out_src),   32'(j));
        check("rr_data",  32'(out_data),  32'((j + 1) * 16));
      end
      tick();
      check("rr_idle", 32'(out_valid), 32'h0);
    end

    // Single pulse on channel 0: visible one edge after the write, one cycle
    in_data = 32'h0000_00A5;
    request = 4'b0001;
    tick();
    request = '0;
    check("pulse_not_yet", 32'(out_valid), 32'h0);
    tick();
    check("pulse_valid", 32'(out_valid), 32'h1);
    check("pulse_data",  32'(out_data),  32'hA5);
    check("pulse_src",   32'(out_src),   32'h0);
    tick();
    check("pulse_gone",  32'(out_valid), 32'h0);

    // Fixed priority: both ch0 words come before both ch3 words
    in_data   = 32'h3100_0001;
    request_f = 4'b1001;
    tick();
    in_data   = 32'h3200_0002;
    tick();
    request_f = '0;
    check("fx_w0_data", 32'(out_data_f), 32'h01);
    check("fx_w0_src",  32'(out_src_f),  32'h0);
    tick();
    check("fx_w1_data", 32'(out_data_f), 32'h02);
    check("fx_w1_src",  32'(out_src_f),  32'h0);
    tick();
    check("fx_w2_data", 32'(out_data_f), 32'h31);
    check("fx_w2_src",  32'(out_src_f),  32'h3);
    tick();
    check("fx_w3_data", 32'(out_data_f), 32'h32);
    check("fx_w3_src",  32'(out_src_f),  32'h3);
    tick();
    check("fx_idle",    32'(out_valid_f), 32'h0);

    // Backpressure: six requests on ch1 with out_ready low
    out_ready = 1'b0;
    accepted  = 0;
    for (int k = 0; k < 6; k++) begin
      in_data = 32'(8'h60 + 8'(k)) << 8;
      request = 4'b0010;
      #1;
      accepted += int'(ready[1]);
      tick();
    end
    request = '0;
    check("bp_sum",    32'(accepted) + 32'(reject_count), 32'd6);
    check("bp_ready1", 32'(ready[1]), 32'h0);
    check("bp_valid",  32'(out_valid), 32'h1);
    check("bp_data",   32'(out_data),  32'h60);
    check("bp_src",    32'(out_src),   32'h1);
    for (int s = 0; s < 3; s++) begin
      tick();
      check("stall_data",  32'(out_data),  32'h60);
      check("stall_src",   32'(out_src),   32'h1);
      check("stall_valid", 32'(out_valid), 32'h1);
    end
    out_ready = 1'b1;
    for (int j = 1; j < accepted; j++) begin
      tick();
      check("drain_data",  32'(out_data),  32'(8'h60 + 8'(j)));
      check("drain_valid", 32'(out_valid), 32'h1);
    end
    tick();
    check("drain_idle", 32'(out_valid), 32'h0);

    // Reset between edges with words buffered on ch2
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      in_data = 32'(8'h71 + 8'(k)) << 16;
      request = 4'b0100;
      tick();
    end
    request = '0;
    check("pre_rst_valid", 32'(out_valid), 32'h1);
    #2 rst = 1'b0;
    #1;
    check("async_valid",  32'(out_valid),    32'h0);
    check("async_ready",  32'(ready),        32'h0);
    check("async_reject", 32'(reject_count), 32'h0);
    tick();
    tick();
    #2 rst = 1'b1;
    out_ready = 1'b1;
    tick();
    check("rel_ready", 32'(ready), 32'hF);
    for (int s = 0; s < 3; s++) begin
      tick();
      check("rel_no_word", 32'(out_valid), 32'h0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
